// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// func3 opcodes, FSM state encodings, step modes and opcode decode helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // All divide/remainder opcodes have func3[2] set.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is a signed operand for MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is a signed operand for MULH, DIV and REM.
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration, shared between shift-add multiply and restoring divide.
// Multiply: hi is the upper product half (bit WIDTH stays 0), lo the multiplier
// being shifted out while product bits shift in.
// Divide: hi is the partial remainder, lo the dividend shifting out; the new
// quotient bit is returned on qbit and lo_next leaves its LSB clear for it.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             mode,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   hi_next,
  output logic [WIDTH-1:0] lo_next,
  output logic             qbit
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Compute both candidate steps and select by mode.
  always_comb begin
    addend  = lo[0] ? operand : '0;
    sum     = hi + {1'b0, addend};
    shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, operand};
    hi_next = '0;
    lo_next = '0;
    qbit    = 1'b0;
    if (mode == MODE_MUL) begin
      hi_next = {1'b0, sum[WIDTH:1]};
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end else begin
      qbit    = ~diff[WIDTH+1];
      hi_next = qbit ? diff[WIDTH:0] : shifted;
      lo_next = {lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on
// acceptance, the magnitude product/quotient is built one bit per cycle, and
// the sign is applied in a single fix-up cycle before the result is registered.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  // Control state
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Operation context captured at acceptance
  logic [2:0]       op_q;
  logic             sign_q;
  logic             special_q;
  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;

  // Acceptance decode
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic             a_neg;
  logic             b_neg;
  logic             is_div;
  logic             sign_d;
  logic             b_zero;
  logic             ovf;
  logic             special_d;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] special_val;

  // Step datapath
  logic             step_mode;
  logic [WIDTH:0]   hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] lo_step;
  logic             qbit;

  // Fix-up datapath
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_d;

  assign busy = (state == S_CALC) || (state == S_FIX);

  // Decode the incoming request: magnitudes, result sign and special cases.
  always_comb begin
    a_s       = a;
    b_s       = b;
    is_div    = op_is_div(op);
    a_neg     = op_a_signed(op) && (a_s < 0);
    b_neg     = op_b_signed(op) && (b_s < 0);
    abs_a     = a_neg ? neg_w(a) : a;
    abs_b     = b_neg ? neg_w(b) : b;
    // Remainder follows the dividend sign; product and quotient use the XOR.
    sign_d    = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    b_zero    = (b == '0);
    ovf       = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == ALL_ONES);
    special_d = is_div && (b_zero || ovf);
    // op[1] distinguishes REM/REMU from DIV/DIVU.
    if (b_zero) begin
      special_val = op[1] ? a : ALL_ONES;
    end else begin
      special_val = (op == OP_DIV) ? a : '0;
    end
  end

  assign step_mode = op_is_div(op_q) ? MODE_DIV : MODE_MUL;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode    (step_mode),
    .hi      (hi),
    .lo      (lo),
    .operand (operand),
    .hi_next (hi_next),
    .lo_next (lo_next),
    .qbit    (qbit)
  );

  // qbit is 0 in multiply mode, and lo_next[0] is 0 in divide mode.
  assign lo_step = {lo_next[WIDTH-1:1], lo_next[0] | qbit};

  // Apply the sign and pick the requested half/quotient/remainder.
  always_comb begin
    prod     = {hi[WIDTH-1:0], lo};
    prod_fix = sign_q ? neg_2w(prod) : prod;
    quo_fix  = sign_q ? neg_w(lo) : lo;
    rem_fix  = sign_q ? neg_w(hi[WIDTH-1:0]) : hi[WIDTH-1:0];
    res_d    = '0;
    if (special_q) begin
      res_d = lo;
    end else begin
      case (op_q)
        OP_MUL:                       res_d = prod_fix[WIDTH-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_fix[2*WIDTH-1:WIDTH];
        OP_DIV, OP_DIVU:              res_d = quo_fix;
        default:                      res_d = rem_fix;
      endcase
    end
  end

  // Sequence IDLE -> CALC -> FIX (or IDLE -> FIX for special cases) and own the outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= special_d ? S_FIX : S_CALC;
            cnt   <= CNT_LOAD;
          end
        end
        S_CALC: begin
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          result <= res_d;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Latch operation context on acceptance, then advance one step per CALC cycle.
  always_ff @(posedge clock) begin
    if ((state == S_IDLE) && start) begin
      op_q      <= op;
      sign_q    <= sign_d;
      special_q <= special_d;
      operand   <= is_div ? abs_b : abs_a;
      hi        <= '0;
      lo        <= special_d ? special_val : (is_div ? abs_a : abs_b);
    end else if (state == S_CALC) begin
      hi <= hi_next;
      lo <= lo_step;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit at WIDTH=32: reset state, every RV32M
// opcode, divide special cases, handshake behaviour and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(
    .WIDTH(WIDTH)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge. Issues one request (cycle 0), scrambles the
  // inputs afterwards, optionally pulses start at cycle pulse_at, and returns at
  // the falling edge of the done cycle (or after the cycle budget expires).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input int exp_cycle,
                        input logic [WIDTH-1:0] exp_res, input int pulse_at);
    int n;
    int bad;
    logic got;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 3'($urandom);
    n     = 1;
    bad   = 0;
    got   = 1'b0;
    while (!got && (n <= exp_cycle + 4)) begin
      @(negedge clock);
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (busy !== 1'b1) bad++;
        if (n == pulse_at) begin
          start = 1'b1;
          op    = OP_DIVU;
          a     = 32'd100;
          b     = 32'd3;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        n++;
      end
    end
    check({tag, "_done_cycle"}, 32'(n), 32'(exp_cycle));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_busy_window"}, 32'(bad), 32'd0);
  endtask

  // One idle cycle after a done: the pulse has ended and the result is held.
  task automatic idle_check(input string tag, input logic [WIDTH-1:0] exp_res);
    @(negedge clock);
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check({tag, "_held"}, result, exp_res);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int dcount;
    reset = 1'b1;
    start = 1'b0;
    op    = OP_MUL;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;

    // Multiply, low half, with latency and busy window
    run_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, 0);
    idle_check("mul", 32'hFFFF_FFEB);

    // High halves; MULHU starts in the MULH done cycle
    run_op("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 0);
    run_op("mulhu_b2b", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 0);
    idle_check("mulhu", 32'hFFFF_FFFE);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF, 0);

    // Division and remainder
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 0);
    run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 0);
    run_op("divu", OP_DIVU, 32'd7, 32'd2, 34, 32'd3, 0);
    run_op("remu", OP_REMU, 32'd7, 32'd2, 34, 32'd1, 0);
    idle_check("remu", 32'd1);

    // Special cases finish two cycles after acceptance
    run_op("div_by0", OP_DIV, 32'd5, 32'd0, 2, 32'hFFFF_FFFF, 0);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 2, 32'hFFFF_FFFF, 0);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 2, 32'd5, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h8000_0000, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'd0, 0);
    idle_check("rem_ovf", 32'd0);

    // Start pulsed at cycle 10 of a multiply is ignored
    run_op("mul_ignore", OP_MUL, 32'h0001_2345, 32'h0000_0100, 34, 32'h0123_4500, 10);
    idle_check("mul_ignore", 32'h0123_4500);

    // Reset during cycle 15 of a divide aborts it
    op    = OP_DIV;
    a     = 32'hFFFF_FF9C;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int i = 2; i <= 15; i++) @(posedge clock);
    @(negedge clock);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    dcount = 0;
    for (int i = 17; i <= 40; i++) begin
      @(negedge clock);
      if (done !== 1'b0) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);

    // Normal operation resumes after the abort
    run_op("div_negb", OP_DIV, 32'd100, 32'hFFFF_FFF9, 34, 32'hFFFF_FFF2, 0);
    run_op("rem_negb", OP_REM, 32'd100, 32'hFFFF_FFF9, 34, 32'd2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
